// File: rtl/alu_step_controller.sv
// Multi-cycle control sequencer for the three-operand ALU datapath: fetches one
// instruction, decodes the opcode and steps the register-transfer strobes.
module alu_step_controller #(
  parameter int OPC_W        = 5,
  parameter int ALU_OP_W     = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                z_in,
  output logic                z_lo_out,
  output logic                z_hi_out,
  output logic                pc_in,
  output logic                mem_read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                gra,
  output logic                grb,
  output logic                grc,
  output logic                r_out,
  output logic                r_in,
  output logic                lo_in,
  output logic                hi_in,
  output logic [ALU_OP_W-1:0] alu_op
);

  // Handshake: start is sampled only in IDLE; busy is high in every other
  // state; done or illegal pulses for one cycle on the last step of a run.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  state_t           state, state_d;
  logic [3:0]       wait_cnt, wait_cnt_d;
  logic [OPC_W-1:0] op_q;
  logic [OPC_W-1:0] ir_op;
  logic             ir_legal;
  logic             op_unary;
  logic             op_muldiv;
  logic             unused_ir;

  assign ir_op     = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign ir_legal  = (ir_op >= OPC_W'(1)) && (ir_op <= OPC_W'(12));
  assign op_unary  = (op_q == OPC_W'(11)) || (op_q == OPC_W'(12));
  assign op_muldiv = (op_q == OPC_W'(3)) || (op_q == OPC_W'(4));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      op_q     <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      if (state == T3) op_q <= ir_op;
    end
  end

  always_comb begin
    state_d    = state;
    wait_cnt_d = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    pc_out     = 1'b0;
    mar_in     = 1'b0;
    inc_pc     = 1'b0;
    z_in       = 1'b0;
    z_lo_out   = 1'b0;
    z_hi_out   = 1'b0;
    pc_in      = 1'b0;
    mem_read   = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    gra        = 1'b0;
    grb        = 1'b0;
    grc        = 1'b0;
    r_out      = 1'b0;
    r_in       = 1'b0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    alu_op     = '0;
    case (state)
      IDLE: if (start) state_d = T0;
      T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
        state_d = T1;
      end
      T1: begin
        // The incremented PC is written back only once, however long memory stalls.
        z_lo_out = 1'b1;
        mem_read = 1'b1;
        pc_in    = (wait_cnt == 4'd0);
        if (mem_ready) begin
          mdr_in  = 1'b1;
          state_d = T2;
        end else if (wait_cnt == WAIT_LAST) begin
          illegal = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt + 4'd1;
        end
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = T3;
      end
      T3: begin
        if (!ir_legal) begin
          illegal = 1'b1;
          state_d = IDLE;
        end else begin
          grb     = 1'b1;
          r_out   = 1'b1;
          y_in    = 1'b1;
          state_d = T4;
        end
      end
      T4: begin
        // Unary ops take their operand from Y, so Rc is not selected.
        grc     = !op_unary;
        r_out   = 1'b1;
        alu_op  = ALU_OP_W'(op_q);
        z_in    = 1'b1;
        state_d = T5;
      end
      T5: begin
        z_lo_out = 1'b1;
        if (op_muldiv) begin
          lo_in   = 1'b1;
          state_d = T6;
        end else begin
          gra     = 1'b1;
          r_in    = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      T6: begin
        z_hi_out = 1'b1;
        hi_in    = 1'b1;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_step_controller.sv
// Directed bench for alu_step_controller: per-cycle vector table plus
// hand-written memory-timeout and back-to-back sequences.
module tb_alu_step_controller;

  typedef logic [21:0] vec_t;

  localparam vec_t BUSY    = vec_t'(1) << 21;
  localparam vec_t DONE    = vec_t'(1) << 20;
  localparam vec_t ILL     = vec_t'(1) << 19;
  localparam vec_t PC_OUT  = vec_t'(1) << 18;
  localparam vec_t MAR_IN  = vec_t'(1) << 17;
  localparam vec_t INC_PC  = vec_t'(1) << 16;
  localparam vec_t Z_IN    = vec_t'(1) << 15;
  localparam vec_t Z_LO    = vec_t'(1) << 14;
  localparam vec_t Z_HI    = vec_t'(1) << 13;
  localparam vec_t PC_IN   = vec_t'(1) << 12;
  localparam vec_t MEM_RD  = vec_t'(1) << 11;
  localparam vec_t MDR_IN  = vec_t'(1) << 10;
  localparam vec_t MDR_OUT = vec_t'(1) << 9;
  localparam vec_t IR_IN   = vec_t'(1) << 8;
  localparam vec_t Y_IN    = vec_t'(1) << 7;
  localparam vec_t GRA     = vec_t'(1) << 6;
  localparam vec_t GRB     = vec_t'(1) << 5;
  localparam vec_t GRC     = vec_t'(1) << 4;
  localparam vec_t R_OUT   = vec_t'(1) << 3;
  localparam vec_t R_IN    = vec_t'(1) << 2;
  localparam vec_t LO_IN   = vec_t'(1) << 1;
  localparam vec_t HI_IN   = vec_t'(1) << 0;

  localparam vec_t E_T0  = BUSY | PC_OUT | MAR_IN | INC_PC | Z_IN;
  localparam vec_t E_T1F = BUSY | Z_LO | PC_IN | MEM_RD;
  localparam vec_t E_T1  = BUSY | Z_LO | MEM_RD;
  localparam vec_t E_T2  = BUSY | MDR_OUT | IR_IN;
  localparam vec_t E_T3  = BUSY | GRB | R_OUT | Y_IN;
  localparam vec_t E_T4B = BUSY | GRC | R_OUT | Z_IN;
  localparam vec_t E_T4U = BUSY | R_OUT | Z_IN;
  localparam vec_t E_T5  = BUSY | Z_LO | GRA | R_IN | DONE;
  localparam vec_t E_T5M = BUSY | Z_LO | LO_IN;
  localparam vec_t E_T6  = BUSY | Z_HI | HI_IN | DONE;

  localparam int K_BIN = 0, K_UNARY = 1, K_MULDIV = 2, K_ILL = 3;

  typedef struct {
    logic       rst;
    logic       st;
    logic       mr;
    logic [4:0] op;
    vec_t       exp;
    logic [3:0] alu;
  } row_t;

  logic        clock = 1'b0;
  logic        reset, start, mem_ready;
  logic [31:0] ir;
  logic        busy, done, illegal, pc_out, mar_in, inc_pc, z_in, z_lo_out, z_hi_out;
  logic        pc_in, mem_read, mdr_in, mdr_out, ir_in, y_in, gra, grb, grc, r_out;
  logic        r_in, lo_in, hi_in;
  logic [3:0]  alu_op;
  vec_t        act;

  int total = 0;
  int bad   = 0;
  row_t tbl[$];
  logic [31:0] exp_q[$];

  alu_step_controller #(.OPC_W(5), .ALU_OP_W(4), .MEM_WAIT_MAX(15)) dut (
    .clock(clock), .reset(reset), .start(start), .ir(ir), .mem_ready(mem_ready),
    .busy(busy), .done(done), .illegal(illegal), .pc_out(pc_out), .mar_in(mar_in),
    .inc_pc(inc_pc), .z_in(z_in), .z_lo_out(z_lo_out), .z_hi_out(z_hi_out),
    .pc_in(pc_in), .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .y_in(y_in), .gra(gra), .grb(grb), .grc(grc), .r_out(r_out),
    .r_in(r_in), .lo_in(lo_in), .hi_in(hi_in), .alu_op(alu_op)
  );

  always #5 clock = ~clock;

  assign act = {busy, done, illegal, pc_out, mar_in, inc_pc, z_in, z_lo_out, z_hi_out,
                pc_in, mem_read, mdr_in, mdr_out, ir_in, y_in, gra, grb, grc, r_out,
                r_in, lo_in, hi_in};

  task automatic check(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, id, got, want);
    end
  endtask

  task automatic invariants(input int id);
    check("bus_excl", id, 32'($countones({pc_out, z_lo_out, z_hi_out, mdr_out, r_out}) <= 1), 32'd1);
    check("done_ill", id, 32'(done & illegal), 32'd0);
  endtask

  task automatic step(input logic r, input logic s, input logic m, input logic [4:0] op,
                      input vec_t e, input logic [3:0] a, input int id);
    @(negedge clock);
    reset     = r;
    start     = s;
    mem_ready = m;
    ir        = {op, 27'h5a5a5a5};
    #1;
    check("strobes", id, 32'(act), 32'(e));
    check("alu_op", id, 32'(alu_op), 32'(a));
    invariants(id);
  endtask

  task automatic p(input logic r, input logic s, input logic m, input logic [4:0] op,
                   input vec_t e, input logic [3:0] a);
    row_t row;
    row.rst = r; row.st = s; row.mr = m; row.op = op; row.exp = e; row.alu = a;
    tbl.push_back(row);
  endtask

  // One full run from IDLE: waits = extra T1 cycles before mem_ready.
  task automatic push_run(input logic [4:0] op, input int kind, input int waits);
    p(0, 1, 0, op, '0, 4'd0);
    p(0, 0, 0, op, E_T0, 4'd0);
    for (int i = 0; i <= waits; i++)
      p(0, 0, i == waits, op, (i == 0 ? E_T1F : E_T1) | (i == waits ? MDR_IN : '0), 4'd0);
    p(0, 1, 0, op, E_T2, 4'd0);
    if (kind == K_ILL) begin
      p(0, 0, 0, op, BUSY | ILL, 4'd0);
    end else begin
      p(0, 1, 0, op, E_T3, 4'd0);
      p(0, 1, 0, op, (kind == K_UNARY) ? E_T4U : E_T4B, op[3:0]);
      if (kind == K_MULDIV) begin
        p(0, 0, 0, op, E_T5M, 4'd0);
        p(0, 0, 0, op, E_T6, 4'd0);
      end else begin
        p(0, 0, 0, op, E_T5, 4'd0);
      end
    end
    p(0, 0, 0, op, '0, 4'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;
    repeat (2) @(posedge clock);

    // Reset in the middle of T4 of an add, then a clean add.
    p(0, 1, 1, 5'd1, '0, 4'd0);
    p(0, 0, 1, 5'd1, E_T0, 4'd0);
    p(0, 0, 1, 5'd1, E_T1F | MDR_IN, 4'd0);
    p(0, 0, 1, 5'd1, E_T2, 4'd0);
    p(0, 0, 1, 5'd1, E_T3, 4'd0);
    p(1, 0, 1, 5'd1, E_T4B, 4'd1);
    p(0, 0, 1, 5'd1, '0, 4'd0);
    push_run(5'd1,  K_BIN,    0);
    push_run(5'd3,  K_MULDIV, 2);
    push_run(5'd12, K_UNARY,  0);
    push_run(5'd11, K_UNARY,  0);
    push_run(5'd4,  K_MULDIV, 0);
    push_run(5'd2,  K_BIN,    1);
    push_run(5'd9,  K_BIN,    0);
    push_run(5'd0,  K_ILL,    0);
    push_run(5'd20, K_ILL,    0);
    push_run(5'd13, K_ILL,    0);
    push_run(5'd31, K_ILL,    0);

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].st, tbl[i].mr, tbl[i].op, tbl[i].exp, tbl[i].alu, i);

    // Memory never answers: abort on the 15th T1 cycle, no mdr_in.
    step(0, 1, 0, 5'd1, '0, 4'd0, 1000);
    step(0, 0, 0, 5'd1, E_T0, 4'd0, 1001);
    for (int c = 2; c <= 16; c++)
      step(0, 0, 0, 5'd1, (c == 2 ? E_T1F : E_T1) | (c == 16 ? ILL : '0), 4'd0, 1000 + c);
    step(0, 0, 0, 5'd1, '0, 4'd0, 1017);

    // start held high: done at cycles 6, 13, 20, 27.
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd13);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd27);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      reset = 1'b0; start = 1'b1; mem_ready = 1'b1; ir = {5'd1, 27'h0};
      #1;
      invariants(2000 + c);
      if (done) begin
        ndone++;
        if (exp_q.size() == 0) check("extra_done", c, 32'd1, 32'd0);
        else check("done_cycle", c, 32'(c), exp_q.pop_front());
      end
    end
    check("done_count", 0, 32'(ndone), 32'd4);
    check("done_missing", 0, 32'(exp_q.size()), 32'd0);

    @(negedge clock);
    reset = 1'b1; start = 1'b0;
    @(negedge clock);
    #1;
    check("reset_idle", 0, 32'(act), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_step_controller.md
Name: alu_step_controller

Overview:
- Multi-cycle control sequencer for the three-operand ALU datapath.
- Each run is started by a start/busy/done handshake. The block fetches one instruction over the memory handshake and decodes its opcode.
- It then drives the step-by-step register-transfer strobes (PC, MAR, MDR, IR, Y, Z, HI/LO, general registers) and the ALU operation select.
- It sits between the top-level CPU control and the datapath. It is the only source of ALU operation selects and Z/HI/LO load enables.

Parameters:
- OPC_W, 5, opcode field width (ir[31:27]).
- ALU_OP_W, 4, width of alu_op (encodes codes 1..12).
- MEM_WAIT_MAX, 15, maximum cycles spent in T1 waiting for mem_ready before aborting.

Ports:
- clock  in  1  single system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; forces IDLE.
- start  in  1  request one instruction cycle; sampled only in IDLE.
- ir  in  32  IR register contents from datapath; opcode = ir[31:27].
- mem_ready  in  1  memory read data valid.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse on final step of a successful instruction.
- illegal  out  1  one-cycle pulse: unsupported opcode or memory timeout.
- pc_out, mar_in, inc_pc, z_in, z_lo_out, z_hi_out, pc_in, mem_read, mdr_in, mdr_out, ir_in, y_in, gra, grb, grc, r_out, r_in, lo_in, hi_in  out  1 each  datapath strobes.
- alu_op  out  ALU_OP_W  ALU select (0 = none).

Behaviour:
- Structure:
  - Registered state plus a 4-bit wait counter.
  - All outputs are decoded combinationally from state, counter, mem_ready and the latched opcode.
  - Reset (including mid-instruction) puts state in IDLE, clears the counter and latched opcode, and drives every output to 0 in the following cycle.
- Opcode legality: legal opcodes are 1..12, with alu_op = opcode[3:0].
  - 1 add, 2 sub, 3 mul, 4 div, 5 shr, 6 shl, 7 ror, 8 rol, 9 and, 10 or, 11 not, 12 neg.
  - Opcodes 0 and 13..31 are illegal.
- IDLE: all outputs 0. start=1 → T0 next cycle. start is ignored while busy.
- T0: pc_out, mar_in, inc_pc, z_in, alu_op=0. → T1.
- T1: z_lo_out, pc_in (first T1 cycle only), mem_read. Counter increments each cycle.
  - mem_ready=1: mdr_in=1 that cycle → T2.
  - Counter reaches MEM_WAIT_MAX with mem_ready=0: illegal=1 → IDLE.
- T2: mdr_out, ir_in. → T3.
- T3: latch opcode from ir (IR is valid this cycle).
  - Illegal opcode: illegal=1, no other strobes → IDLE.
  - Otherwise: grb, r_out, y_in → T4.
- T4: grc, r_out, alu_op=latched op, z_in.
  - Opcodes 11 and 12 are unary: grc=0, r_out=1 (the Rb path is reused via Y). → T5.
- T5:
  - Opcodes 3/4: z_lo_out, lo_in → T6.
  - Otherwise: z_lo_out, gra, r_in, done=1 → IDLE.
- T6 (opcodes 3/4 only): z_hi_out, hi_in, done=1 → IDLE.
- Latency from start edge to done:
  - Non-mul/div: 6 cycles, plus (n−1) for n T1 cycles.
  - mul/div: 7 cycles, plus the same T1 extension.
- start may be asserted in the cycle done is high. It is sampled in IDLE on the next cycle, so there is a 1-cycle IDLE gap between instructions.
- Mutual exclusion: at most one of pc_out, z_lo_out, z_hi_out, mdr_out, r_out is high in any cycle.
- Output pulses: done and illegal never assert together; each is high for exactly one cycle per event.

Test Plan:
- Reset mid-T4 of an add → next cycle all outputs 0, busy=0; a new start then runs a full 6-cycle sequence.
- start with mem_ready tied 1, ir opcode=1 (add) → strobe sequence T0..T5 exactly as specified, alu_op=1 only in T4, done at cycle 6, busy high cycles 1–6.
- Opcode=3 (mul), mem_ready delayed 3 cycles → T1 lasts 3 cycles, pc_in only in first; lo_in in T5, hi_in+done in T6; done at cycle 9.
- Opcode=12 (neg) → T4 has grc=0, r_out=1, alu_op=12; done at cycle 6.
- Opcode=0 and opcode=20 → illegal pulse in T3, no y_in, busy drops next cycle, done never asserted.
- mem_ready held 0 → illegal after MEM_WAIT_MAX=15 T1 cycles, return to IDLE, mdr_in never asserted.
- start held high continuously with opcode=1 → back-to-back instructions, done every 7 cycles; start pulses during busy have no effect.
